// File: rtl/execute_muldiv_unit.sv
// rtl/execute_muldiv_unit.sv - iterative RV32M/RV64M multiply/divide unit for the Execute stage
//
// Purpose: radix-2 shift-add multiplier and restoring divider sharing one
// 2*XLEN accumulator. One bit is processed per CALC cycle. Divide-by-zero and
// signed overflow are resolved at accept and skip CALC.
//
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   flush_i                   kill accepted / in-flight operation
//   valid_i, ready_o          request handshake (ready_o high only in IDLE)
//   op_i, src_a_i, src_b_i    M-extension funct3 and forwarded operands
//   tag_i                     destination register tag
//   valid_o, ready_i          result handshake
//   result_o, tag_o           registered result and its tag
//   busy_o                    stall request, high whenever not IDLE
module execute_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  src_a_i,
    input  logic [XLEN-1:0]  src_b_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   acc_q, acc_d;        // {product hi, multiplier} or {remainder, quotient/dividend}
    logic                neg_q, neg_d;        // product / quotient must be negated
    logic                rneg_q, rneg_d;      // remainder must be negated (dividend sign)
    logic [XLEN-1:0]     result_q, result_d;

    // Operand decode at accept
    logic            in_is_div;
    logic            a_signed, b_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_by_zero, div_ovf;

    always_comb begin
        in_is_div   = op_i[2];
        // DIV/REM are signed (funct3[0]=0); MULH signs both, MULHSU signs rs1 only.
        a_signed    = in_is_div ? ~op_i[0] : (op_i[1:0] == 2'b01 || op_i[1:0] == 2'b10);
        b_signed    = in_is_div ? ~op_i[0] : (op_i[1:0] == 2'b01);
        a_neg       = a_signed & src_a_i[XLEN-1];
        b_neg       = b_signed & src_b_i[XLEN-1];
        a_mag       = a_neg ? (~src_a_i + 1'b1) : src_a_i;
        b_mag       = b_neg ? (~src_b_i + 1'b1) : src_b_i;
        div_by_zero = in_is_div & (src_b_i == '0);
        div_ovf     = in_is_div & ~op_i[0] & (src_a_i == MOST_NEG) & (&src_b_i);
    end

    // One iteration of each datapath
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_qbit;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        // Shift-add: add multiplicand to the high half when the current
        // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};

        // Restoring divide: bring in the next dividend bit, trial-subtract,
        // keep the difference only when it did not borrow.
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_qbit  = ~div_diff[XLEN];
        div_next  = {(div_qbit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                     acc_q[XLEN-2:0], div_qbit};
    end

    // Final sign fix-up and result selection
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo, rem;
    logic [XLEN-1:0]   mul_res, div_res;

    always_comb begin
        prod_s  = neg_q ? (~mul_next + 1'b1) : mul_next;
        mul_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        quo     = div_next[XLEN-1:0];
        rem     = div_next[2*XLEN-1:XLEN];
        if (op_q[1]) begin
            div_res = rneg_q ? (~rem + 1'b1) : rem;
        end else begin
            div_res = neg_q ? (~quo + 1'b1) : quo;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        tag_d    = tag_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;

        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (valid_i) begin
                        op_d   = op_i;
                        tag_d  = tag_i;
                        cnt_d  = '0;
                        neg_d  = a_neg ^ b_neg;
                        rneg_d = a_neg;
                        if (in_is_div) begin
                            opnd_d = b_mag;
                            acc_d  = {{XLEN{1'b0}}, a_mag};
                        end else begin
                            opnd_d = a_mag;
                            acc_d  = {{XLEN{1'b0}}, b_mag};
                        end
                        if (div_by_zero) begin
                            result_d = op_i[1] ? src_a_i : '1;
                            state_d  = S_DONE;
                        end else if (div_ovf) begin
                            result_d = op_i[1] ? '0 : src_a_i;
                            state_d  = S_DONE;
                        end else begin
                            state_d  = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    if (cnt_q == CNT_LAST) begin
                        result_d = op_q[2] ? div_res : mul_res;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (ready_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            tag_q    <= '0;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign ready_o  = (state_q == S_IDLE);
    assign busy_o   = (state_q != S_IDLE);
    assign valid_o  = (state_q == S_DONE);
    assign result_o = result_q;
    assign tag_o    = tag_q;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// tb/tb_execute_muldiv_unit.sv - self-checking bench for execute_muldiv_unit
module tb_execute_muldiv_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             clk;
    logic             reset_n_i;
    logic             flush_i;
    logic             valid_i;
    logic             ready_o;
    logic [2:0]       op_i;
    logic [XLEN-1:0]  src_a_i;
    logic [XLEN-1:0]  src_b_i;
    logic [TAG_W-1:0] tag_i;
    logic             valid_o;
    logic             ready_i;
    logic [XLEN-1:0]  result_o;
    logic [TAG_W-1:0] tag_o;
    logic             busy_o;

    execute_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n_i),
        .flush_i   (flush_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .op_i      (op_i),
        .src_a_i   (src_a_i),
        .src_b_i   (src_b_i),
        .tag_i     (tag_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .result_o  (result_o),
        .tag_o     (tag_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
    } vec_t;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
    } sb_t;

    sb_t  sbq[$];
    vec_t vecs[15];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa64, sb64, ua64, ub64, p;
        logic signed [31:0] sa, sb, sr;
        logic [31:0]        r;
        logic               ovf;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ua64 = {32'b0, a};
        ub64 = {32'b0, b};
        sa   = a;
        sb   = b;
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r    = '0;
        case (op)
            3'd0: begin p = ua64 * ub64; r = p[31:0]; end
            3'd1: begin p = sa64 * sb64; r = p[63:32]; end
            3'd2: begin p = sa64 * ub64; r = p[63:32]; end
            3'd3: begin p = ua64 * ub64; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (ovf) r = a;
                else begin sr = sa / sb; r = sr; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (ovf) r = 32'h0;
                else begin sr = sa % sb; r = sr; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Issue one op from a negedge and follow it through handoff; returns at a
    // negedge with the unit back in IDLE. hold = DONE cycles with ready_i low.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input logic [31:0] exp,
                          input bit special, input int hold, input string name);
        int  cyc;
        sb_t e;
        chk({name, "_ready_in"}, ready_o, 1);
        valid_i = 1'b1;
        op_i    = op;
        src_a_i = a;
        src_b_i = b;
        tag_i   = tag;
        ready_i = (hold == 0);
        sbq.push_back('{exp, tag});
        @(negedge clk);
        valid_i = 1'b0;
        cyc = 0;
        while (!valid_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_latency"}, cyc, special ? 0 : XLEN);
        for (int h = 0; h < hold; h++) begin
            chk({name, "_hold_valid"}, valid_o, 1);
            chk({name, "_hold_ready"}, ready_o, 0);
            chk({name, "_hold_busy"}, busy_o, 1);
            chk({name, "_hold_result"}, result_o, exp);
            @(negedge clk);
        end
        ready_i = 1'b1;
        if (valid_o && ready_i) begin
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk({name, "_result"}, result_o, e.res);
                chk({name, "_tag"}, tag_o, e.tag);
            end else begin
                chk({name, "_scoreboard_empty"}, 1, 0);
            end
        end else begin
            chk({name, "_valid_timeout"}, valid_o, 1);
            sbq.delete();
        end
        @(negedge clk);
        chk({name, "_valid_after"}, valid_o, 0);
        chk({name, "_ready_after"}, ready_o, 1);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        bit          rsp;

        reset_n_i = 1'b0;
        flush_i   = 1'b0;
        valid_i   = 1'b0;
        op_i      = '0;
        src_a_i   = '0;
        src_b_i   = '0;
        tag_i     = '0;
        ready_i   = 1'b1;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        1'b0};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         1'b0};
        vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1'b1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1};
        vecs[12] = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1};
        vecs[13] = '{3'd7, 32'd5,          32'd0,         32'd5,         1'b1};
        vecs[14] = '{3'd1, 32'hFFFF_FFFF,  32'd7,         32'hFFFF_FFFF, 1'b0};

        #12;
        chk("rst_valid",  valid_o,  0);
        chk("rst_result", result_o, 0);
        chk("rst_tag",    tag_o,    0);
        chk("rst_busy",   busy_o,   0);
        chk("rst_ready",  ready_o,  1);
        @(negedge clk);
        reset_n_i = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, TAG_W'(i + 1), vecs[i].exp,
                   vecs[i].special, 0, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 10; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            rsp = rop[2] && (rb == 0 || (!rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF));
            run_op(rop, ra, rb, TAG_W'(i + 16), model(rop, ra, rb), rsp, 0, $sformatf("rnd%0d", i));
        end

        // Backpressure: three DONE cycles with ready_i low
        run_op(3'd0, 32'd3, 32'd5, 5'd30, 32'd15, 1'b0, 3, "backpressure");
        run_op(3'd6, 32'd5, 32'd0, 5'd29, 32'd5, 1'b1, 2, "bp_special");

        // Flush on CALC cycle 10
        valid_i = 1'b1;
        op_i    = 3'd5;
        src_a_i = 32'd100;
        src_b_i = 32'd7;
        tag_i   = 5'd9;
        @(negedge clk);
        valid_i = 1'b0;
        chk("flush_busy_calc", busy_o, 1);
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush_busy",  busy_o,  0);
        chk("flush_ready", ready_o, 1);
        chk("flush_valid", valid_o, 0);
        run_op(3'd7, 32'd100, 32'd7, 5'd10, 32'd2, 1'b0, 0, "after_flush");

        // flush_i together with valid_i in IDLE: nothing accepted
        valid_i = 1'b1;
        flush_i = 1'b1;
        op_i    = 3'd0;
        src_a_i = 32'd2;
        src_b_i = 32'd2;
        @(negedge clk);
        valid_i = 1'b0;
        flush_i = 1'b0;
        chk("flush_idle_busy", busy_o, 0);
        @(negedge clk);
        chk("flush_idle_valid", valid_o, 0);

        // Flush in DONE discards the result
        valid_i = 1'b1;
        op_i    = 3'd4;
        src_a_i = 32'd5;
        src_b_i = 32'd0;
        tag_i   = 5'd3;
        ready_i = 1'b0;
        @(negedge clk);
        valid_i = 1'b0;
        chk("done_flush_pre", valid_o, 1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        ready_i = 1'b1;
        chk("done_flush_valid", valid_o, 0);
        chk("done_flush_ready", ready_o, 1);

        run_op(3'd0, 32'd6, 32'd7, 5'd12, 32'd42, 1'b0, 0, "pre_reset");

        // Asynchronous reset mid-CALC
        valid_i = 1'b1;
        op_i    = 3'd0;
        src_a_i = 32'h1234;
        src_b_i = 32'h10;
        tag_i   = 5'd7;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("async_rst_valid",  valid_o,  0);
        chk("async_rst_result", result_o, 0);
        chk("async_rst_tag",    tag_o,    0);
        chk("async_rst_busy",   busy_o,   0);
        chk("async_rst_ready",  ready_o,  1);
        @(negedge clk);
        reset_n_i = 1'b1;
        @(negedge clk);
        run_op(3'd5, 32'd9, 32'd3, 5'd21, 32'd3, 1'b0, 0, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
